// File: rtl/conv1d_multi_filter_engine.sv
// conv1d_multi_filter_engine: NUM_FILTERS 1-D filters over one shared IFmap
// stream, runtime size/stride, one tap per cycle, optional psum add.
module conv1d_multi_filter_engine #(
  parameter int DATA_WIDTH      = 8,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int ACC_WIDTH       = 24,
  parameter int NUM_FILTERS     = 4,
  parameter int MAX_FILTER_SIZE = 8,
  parameter int FS_WIDTH        = 4,
  parameter int STRIDE_WIDTH    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [FS_WIDTH-1:0]              filter_size,
  input  logic [STRIDE_WIDTH-1:0]          stride,
  input  logic                             psum_mode,
  input  logic                             w_wr_en,
  input  logic [$clog2(NUM_FILTERS)-1:0]   w_filter,
  input  logic [FS_WIDTH-1:0]              w_tap,
  input  logic [WEIGHT_WIDTH-1:0]          w_data,
  input  logic [DATA_WIDTH-1:0]            if_data,
  input  logic                             if_valid,
  input  logic                             if_last,
  output logic                             if_ready,
  input  logic [NUM_FILTERS*ACC_WIDTH-1:0] psum_in,
  input  logic                             psum_valid,
  output logic                             psum_ready,
  output logic [NUM_FILTERS*ACC_WIDTH-1:0] out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);
  localparam int FIW = $clog2(NUM_FILTERS);
  localparam int CW  = (FS_WIDTH > STRIDE_WIDTH) ? FS_WIDTH : STRIDE_WIDTH;
  localparam int PW  = DATA_WIDTH + WEIGHT_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_MAC, S_PSUM, S_OUT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [FS_WIDTH-1:0]            fs_q, tap_q, tap_idx;
  logic [STRIDE_WIDTH-1:0]        stride_q;
  logic [CW-1:0]                  cnt_q, need_q;
  logic                           psum_q, last_q, err_q;
  logic signed [DATA_WIDTH-1:0]   win_q [MAX_FILTER_SIZE];
  logic signed [WEIGHT_WIDTH-1:0] w_q [NUM_FILTERS][MAX_FILTER_SIZE];
  logic signed [ACC_WIDTH-1:0]    acc_q [NUM_FILTERS];
  logic signed [DATA_WIDTH-1:0]   tap_data;
  logic signed [WEIGHT_WIDTH-1:0] tap_w [NUM_FILTERS];
  logic signed [PW-1:0]           prod [NUM_FILTERS];
  logic cfg_ok, accept, complete, tap_done, w_ok;

  assign cfg_ok = (filter_size != '0)
                && (filter_size <= FS_WIDTH'(MAX_FILTER_SIZE))
                && (stride != '0);
  assign accept   = (state_q == S_FILL) && if_valid;
  assign complete = accept && (cnt_q + CW'(1) == need_q);
  assign tap_done = (tap_q == fs_q - FS_WIDTH'(1));
  // win_q[0] is the newest element, so tap k sits fs-1-k slots back
  assign tap_idx  = fs_q - FS_WIDTH'(1) - tap_q;
  assign w_ok = (state_q == S_IDLE) && w_wr_en
              && (int'(w_tap) < MAX_FILTER_SIZE)
              && (int'(w_filter) < NUM_FILTERS);

  always_comb begin
    tap_data = '0;
    for (int i = 0; i < MAX_FILTER_SIZE; i++)
      if (tap_idx == FS_WIDTH'(i)) tap_data = win_q[i];
    for (int f = 0; f < NUM_FILTERS; f++) begin
      tap_w[f] = '0;
      for (int i = 0; i < MAX_FILTER_SIZE; i++)
        if (tap_q == FS_WIDTH'(i)) tap_w[f] = w_q[f][i];
      prod[f] = PW'(tap_data) * PW'(tap_w[f]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start && cfg_ok) state_d = S_FILL;
      S_FILL: begin
        if (complete)               state_d = S_MAC;
        else if (accept && if_last) state_d = S_DONE;
      end
      S_MAC:  if (tap_done) state_d = psum_q ? S_PSUM : S_OUT;
      S_PSUM: if (psum_valid) state_d = S_OUT;
      S_OUT:  if (out_ready) state_d = last_q ? S_DONE : S_FILL;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_q     <= '0;
      tap_q    <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
      need_q   <= '0;
      psum_q   <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      win_q    <= '{default: '0};
      w_q      <= '{default: '0};
      acc_q    <= '{default: '0};
    end else begin
      err_q <= (state_q == S_IDLE) && start && !cfg_ok;
      if (w_ok)
        for (int f = 0; f < NUM_FILTERS; f++)
          for (int i = 0; i < MAX_FILTER_SIZE; i++)
            if (w_filter == FIW'(f) && w_tap == FS_WIDTH'(i))
              w_q[f][i] <= w_data;
      if (state_q == S_IDLE && start && cfg_ok) begin
        fs_q     <= filter_size;
        stride_q <= stride;
        psum_q   <= psum_mode;
        cnt_q    <= '0;
        need_q   <= CW'(filter_size);
        last_q   <= 1'b0;
        tap_q    <= '0;
      end
      if (accept) begin
        win_q[0] <= if_data;
        for (int i = 1; i < MAX_FILTER_SIZE; i++)
          win_q[i] <= win_q[i-1];
        if (complete) begin
          cnt_q  <= '0;
          need_q <= CW'(stride_q);
          last_q <= if_last;
          tap_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
      if (state_q == S_MAC) begin
        for (int f = 0; f < NUM_FILTERS; f++)
          acc_q[f] <= acc_q[f] + ACC_WIDTH'(prod[f]);
        tap_q <= tap_q + FS_WIDTH'(1);
      end
      if (state_q == S_PSUM && psum_valid)
        for (int f = 0; f < NUM_FILTERS; f++)
          acc_q[f] <= acc_q[f]
                    + $signed(psum_in[f*ACC_WIDTH +: ACC_WIDTH]);
      if (state_q == S_OUT && out_ready)
        acc_q <= '{default: '0};
    end
  end

  always_comb begin
    if_ready   = (state_q == S_FILL);
    psum_ready = (state_q == S_PSUM);
    out_valid  = (state_q == S_OUT);
    out_last   = (state_q == S_OUT) && last_q;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    error      = err_q;
    out_data   = '0;
    for (int f = 0; f < NUM_FILTERS; f++)
      out_data[f*ACC_WIDTH +: ACC_WIDTH] = acc_q[f];
  end

endmodule

// File: tb/tb_conv1d_multi_filter_engine.sv
// tb_conv1d_multi_filter_engine: randomized rows against a windowed-sum
// reference model; a second 8-bit-accumulator instance checks wraparound.
`timescale 1ns/1ps
module tb_conv1d_multi_filter_engine;
  localparam int NF   = 4;
  localparam int MAXF = 8;
  localparam int AW   = 24;
  localparam int AW8  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [3:0] filter_size = '0;
  logic [3:0] stride = '0;
  logic psum_mode = 1'b0;
  logic w_wr_en = 1'b0;
  logic [1:0] w_filter = '0;
  logic [3:0] w_tap = '0;
  logic [7:0] w_data = '0;
  logic [7:0] if_data = '0;
  logic if_valid = 1'b0;
  logic if_last = 1'b0;
  logic [NF*AW-1:0] psum_in = '0;
  logic psum_valid = 1'b0;
  logic out_ready = 1'b0;
  logic if_ready, psum_ready, out_valid, out_last, busy, done, error;
  logic [NF*AW-1:0] out_data;
  logic [NF*AW8-1:0] psum8, out_data8;
  logic if_ready8, psum_ready8, out_valid8, out_last8;
  logic busy8, done8, error8;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NF; g++) begin : g_p8
    assign psum8[g*AW8 +: AW8] = psum_in[g*AW +: AW8];
  end

  conv1d_multi_filter_engine u_dut (
    .clk(clk), .reset(reset), .start(start),
    .filter_size(filter_size), .stride(stride), .psum_mode(psum_mode),
    .w_wr_en(w_wr_en), .w_filter(w_filter), .w_tap(w_tap), .w_data(w_data),
    .if_data(if_data), .if_valid(if_valid), .if_last(if_last),
    .if_ready(if_ready), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
    .error(error)
  );

  conv1d_multi_filter_engine #(.ACC_WIDTH(AW8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start),
    .filter_size(filter_size), .stride(stride), .psum_mode(psum_mode),
    .w_wr_en(w_wr_en), .w_filter(w_filter), .w_tap(w_tap), .w_data(w_data),
    .if_data(if_data), .if_valid(if_valid), .if_last(if_last),
    .if_ready(if_ready8), .psum_in(psum8), .psum_valid(psum_valid),
    .psum_ready(psum_ready8), .out_data(out_data8), .out_valid(out_valid8),
    .out_ready(out_ready), .out_last(out_last8), .busy(busy8), .done(done8),
    .error(error8)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int wm [NF][MAXF];
  int strm [$];
  logic [NF*AW-1:0] psv [$];
  logic [NF*AW-1:0] exp_d [$];
  logic [NF*AW8-1:0] exp8 [$];
  bit exp_l [$];
  int got_f0 [$];
  int got8_f0 [$];

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each window ends at element fs + j*stride (1-based) and covers the fs
  // elements before it; the row's last result is the one ending at element n.
  task automatic build_exp(input int fs, input int st, input bit pm,
                           input int n);
    int j, s;
    logic [NF*AW-1:0] d;
    logic [NF*AW8-1:0] d8;
    exp_d.delete(); exp8.delete(); exp_l.delete();
    j = 0;
    for (int e = fs; e <= n; e += st) begin
      for (int f = 0; f < NF; f++) begin
        s = 0;
        for (int k = 0; k < fs; k++) s += strm[e-fs+k] * wm[f][k];
        if (pm) s += int'($signed(psv[j][f*AW +: AW]));
        d[f*AW +: AW] = s[AW-1:0];
        d8[f*AW8 +: AW8] = s[AW8-1:0];
      end
      exp_d.push_back(d);
      exp8.push_back(d8);
      exp_l.push_back(e == n);
      j++;
    end
  endtask

  task automatic wr_w(input int f, input int k, input int v);
    logic [7:0] b;
    b = 8'(v);
    @(negedge clk);
    w_wr_en = 1'b1; w_filter = 2'(f); w_tap = 4'(k); w_data = b;
    @(negedge clk);
    w_wr_en = 1'b0;
    wm[f][k] = int'($signed(b));
  endtask

  task automatic rand_w();
    for (int f = 0; f < NF; f++)
      for (int k = 0; k < MAXF; k++)
        wr_w(f, k, int'($urandom_range(0, 255)));
  endtask

  task automatic run_row(input int fs, input int st, input bit pm,
                         input int n, input int hold, input int pgap);
    int idx, wi, pi, t, hcnt, pw, lat;
    bit fin, pv;
    int hs_t [$];
    build_exp(fs, st, pm, n);
    got_f0.delete(); got8_f0.delete();
    @(negedge clk);
    start = 1'b1; filter_size = 4'(fs); stride = 4'(st); psum_mode = pm;
    @(negedge clk);
    start = 1'b0;
    check("row_busy", busy, 1);
    idx = 0; wi = 0; pi = 0; t = 0; fin = 0; pv = 0; pw = pgap; hcnt = 0;
    lat = fs + 1 + (pm ? pgap + 1 : 0);
    while (!fin && t < 2000) begin
      if (done) begin
        check("row_count", wi, exp_d.size());
        fin = 1;
      end else begin
        start = ($urandom_range(0, 7) == 0);
        filter_size = 4'($urandom); stride = 4'($urandom);
        w_wr_en = 1'b1; w_filter = 2'($urandom);
        w_tap = 4'($urandom); w_data = 8'($urandom);
        if_valid = 1'b0; if_last = 1'b0; if_data = 8'($urandom);
        if (if_ready) begin
          if (idx < n && $urandom_range(0, 3) != 0) begin
            if_valid = 1'b1; if_data = 8'(strm[idx]);
            if_last = (idx == n - 1); idx++;
            if (idx >= fs && (idx - fs) % st == 0) hs_t.push_back(t);
          end
        end else begin
          if_valid = 1'($urandom);
        end
        psum_valid = 1'b0; psum_in = {$urandom, $urandom, $urandom};
        if (psum_ready) begin
          check("psum_wait", out_valid, 0);
          if (pw > 0) pw--;
          else if (pi < psv.size()) begin
            psum_valid = 1'b1; psum_in = psv[pi]; pi++; pw = pgap;
          end
        end else begin
          psum_valid = 1'($urandom);
        end
        out_ready = 1'b0;
        if (out_valid) begin
          if (wi >= exp_d.size()) begin
            check("extra_out", out_valid, 0);
            out_ready = 1'b1;
          end else begin
            if (!pv) begin
              hcnt = (hold < 0) ? int'($urandom_range(0, 2)) : hold;
              if (hs_t.size() > 0) check("latency", t - hs_t.pop_front(), lat);
            end
            check("if_ready_out", if_ready, 0);
            check("out_data", out_data, exp_d[wi]);
            check("out_data8", out_data8, exp8[wi]);
            check("out_last", out_last, exp_l[wi]);
            if (hcnt > 0) hcnt--;
            else begin
              out_ready = 1'b1;
              got_f0.push_back(int'($signed(out_data[AW-1:0])));
              got8_f0.push_back(int'($signed(out_data8[AW8-1:0])));
              wi++;
            end
          end
        end
        pv = out_valid && !out_ready;
        @(negedge clk);
        t++;
      end
    end
    start = 1'b0; w_wr_en = 1'b0; if_valid = 1'b0; if_last = 1'b0;
    psum_valid = 1'b0; out_ready = 1'b0;
    if (!fin) check("row_timeout", fin, 1);
    @(negedge clk);
    check("done_pulse", {busy, done}, 0);
  endtask

  task automatic check_f0(input string tag, input int n, input int e0,
                          input int e1, input int e2);
    int ev [3];
    ev = '{e0, e1, e2};
    check(tag, got_f0.size(), n);
    for (int i = 0; i < n && i < got_f0.size(); i++)
      check(tag, got_f0[i], ev[i]);
  endtask

  task automatic bad_start(input int fs, input int st);
    @(negedge clk);
    start = 1'b1; filter_size = 4'(fs); stride = 4'(st);
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", error, 1);
    check("err_busy", busy, 0);
    @(negedge clk);
    check("err_clear", {error, busy}, 0);
  endtask

  task automatic seq_stream(input int n);
    strm.delete();
    for (int i = 1; i <= n; i++) strm.push_back(i);
  endtask

  task automatic rand_stream(input int n);
    strm.delete();
    for (int i = 0; i < n; i++) strm.push_back(int'($urandom_range(0, 255)) - 128);
  endtask

  task automatic outs_zero(input string tag);
    check(tag, {if_ready, psum_ready, out_valid, out_last, busy, done,
                error, out_data}, 0);
    check(tag, {if_ready8, psum_ready8, out_valid8, out_last8, busy8,
                done8, error8, out_data8}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fs, st, n;
    bit pm;
    for (int f = 0; f < NF; f++)
      for (int k = 0; k < MAXF; k++) wm[f][k] = 0;
    repeat (3) @(negedge clk);
    outs_zero("reset_outs");
    reset = 1'b1;

    rand_w();
    for (int k = 0; k < 3; k++) wr_w(0, k, k + 1);
    seq_stream(5);
    run_row(3, 1, 0, 5, 0, 0);
    check_f0("t1_f0", 3, 14, 20, 26);

    wr_w(0, 0, 1); wr_w(0, 1, 1);
    seq_stream(6);
    run_row(2, 2, 0, 6, 0, 0);
    check_f0("t2_s2", 3, 3, 7, 11);
    seq_stream(7);
    run_row(2, 3, 0, 7, 0, 0);
    check_f0("t2_s3", 2, 3, 9, 0);

    wr_w(0, 1, 2); wr_w(0, 2, 3);
    psv.delete();
    for (int i = 0; i < 3; i++) psv.push_back({4{24'd100}});
    seq_stream(5);
    run_row(3, 1, 1, 5, 0, 5);
    check_f0("t3_psum", 3, 114, 120, 126);

    rand_w();
    rand_stream(12);
    run_row(5, 2, 0, 12, 4, 0);

    bad_start(0, 1);
    bad_start(3, 0);
    bad_start(MAXF + 1, 1);
    for (int f = 0; f < NF; f++)
      for (int k = 0; k < MAXF; k++) wr_w(f, k, 255);
    strm.delete();
    for (int i = 0; i < 4; i++) strm.push_back(-128);
    run_row(3, 1, 0, 4, 0, 0);
    check("t5_wrap_n", got8_f0.size(), 2);
    if (got8_f0.size() > 0) check("t5_wrap", got8_f0[0], -128);

    @(negedge clk);
    start = 1'b1; filter_size = 4'd4; stride = 4'd1; psum_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !(busy && !if_ready && !out_valid); i++) begin
      if_valid = if_ready; if_data = 8'($urandom); if_last = 1'b0;
      @(negedge clk);
    end
    if_valid = 1'b0;
    check("t6_in_mac", {busy, if_ready, out_valid, psum_ready}, 4'b1000);
    reset = 1'b0;
    #1;
    outs_zero("t6_async");
    @(negedge clk);
    outs_zero("t6_held");
    reset = 1'b1;
    for (int f = 0; f < NF; f++)
      for (int k = 0; k < MAXF; k++) wm[f][k] = 0;
    rand_stream(6);
    run_row(3, 1, 0, 6, -1, 0);
    for (int k = 0; k < 3; k++) wr_w(0, k, k + 1);
    seq_stream(5);
    run_row(3, 1, 0, 5, 0, 0);
    check_f0("t6_rerun", 3, 14, 20, 26);

    for (int r = 0; r < 8; r++) begin
      rand_w();
      fs = int'($urandom_range(1, MAXF));
      st = int'($urandom_range(1, 6));
      n  = int'($urandom_range(1, 20));
      pm = 1'($urandom);
      rand_stream(n);
      psv.delete();
      for (int i = 0; i < 20; i++) psv.push_back({$urandom, $urandom, $urandom});
      run_row(fs, st, pm, n, -1, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
